// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, sync, strobes and a blank-gated RGB path.
// Define VTG_CENTER_EN to latch h_shift/v_shift at each frame start for runtime sync centring.
module video_timing_gen #(
    parameter int RGB_W    = 12,
    parameter int CNT_W    = 9,
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 23,
    parameter int H_SYNC   = 31,
    parameter int H_BP     = 42,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ce_pix,
    input  logic [RGB_W-1:0]        rgb_in,
    input  logic signed [3:0]       h_shift,
    input  logic signed [3:0]       v_shift,
    output logic [CNT_W-1:0]        hpos,
    output logic [CNT_W-1:0]        vpos,
    output logic                    hblank,
    output logic                    vblank,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    field,
    output logic [RGB_W-1:0]        rgb_out,
    output logic                    de_out
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

    localparam logic signed [CNT_W:0] HS_NOM = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic signed [CNT_W:0] HS_MIN = (CNT_W+1)'(H_ACTIVE);
    localparam logic signed [CNT_W:0] HS_MAX = (CNT_W+1)'(H_TOTAL - H_SYNC);
    localparam logic signed [CNT_W:0] VS_NOM = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic signed [CNT_W:0] VS_MIN = (CNT_W+1)'(V_ACTIVE);
    localparam logic signed [CNT_W:0] VS_MAX = (CNT_W+1)'(V_TOTAL - V_SYNC);
    localparam logic [CNT_W:0]        HS_LEN = (CNT_W+1)'(H_SYNC);
    localparam logic [CNT_W:0]        VS_LEN = (CNT_W+1)'(V_SYNC);

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    // Sync start = nominal + signed shift, clamped so the pulse never leaves blanking.
    function automatic logic [CNT_W:0] sync_start(
        input logic signed [CNT_W:0] nominal,
        input logic signed [3:0]     shift,
        input logic signed [CNT_W:0] lo,
        input logic signed [CNT_W:0] hi
    );
        logic signed [CNT_W:0] raw;
        raw = nominal + $signed({{(CNT_W-3){shift[3]}}, shift});
        if (raw < lo) begin
            sync_start = lo;
        end else if (raw > hi) begin
            sync_start = hi;
        end else begin
            sync_start = raw;
        end
    endfunction

    function automatic logic in_window(
        input logic [CNT_W-1:0] pos,
        input logic [CNT_W:0]   start,
        input logic [CNT_W:0]   len
    );
        logic [CNT_W:0] p;
        p         = {1'b0, pos};
        in_window = (p >= start) && (p < (start + len));
    endfunction

    logic [CNT_W-1:0] hpos_r;
    logic [CNT_W-1:0] vpos_r;
    logic             hblank_r;
    logic             vblank_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             field_r;
    logic [RGB_W-1:0] rgb_out_r;
    logic             de_out_r;

    logic [CNT_W-1:0] h_nxt_s;
    logic [CNT_W-1:0] v_nxt_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             frame_wrap_s;
    logic signed [3:0] hs_lat_s;
    logic signed [3:0] vs_lat_s;
    logic [CNT_W:0]   hs0_s;
    logic [CNT_W:0]   vs0_s;

    // Next-count computation shared by the counters and the flag decode.
    always_comb begin
        h_wrap_s = (hpos_r == H_LAST);
        v_wrap_s = (vpos_r == V_LAST);
        if (h_wrap_s) begin
            h_nxt_s = {CNT_W{1'b0}};
            if (v_wrap_s) begin
                v_nxt_s = {CNT_W{1'b0}};
            end else begin
                v_nxt_s = vpos_r + CNT_W'(1);
            end
        end else begin
            h_nxt_s = hpos_r + CNT_W'(1);
            v_nxt_s = vpos_r;
        end
    end

    assign frame_wrap_s = h_wrap_s & v_wrap_s;

`ifdef VTG_CENTER_EN
    logic signed [3:0] hs_lat_r;
    logic signed [3:0] vs_lat_r;

    // Shifts are captured on the frame wrap so a frame never changes sync position midway.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hs_lat_r <= 4'sd0;
            vs_lat_r <= 4'sd0;
        end else if (ce_pix && frame_wrap_s) begin
            hs_lat_r <= h_shift;
            vs_lat_r <= v_shift;
        end
    end

    assign hs_lat_s = hs_lat_r;
    assign vs_lat_s = vs_lat_r;
`else
    logic unused_shift_s;
    assign unused_shift_s = ^{h_shift, v_shift};
    assign hs_lat_s       = 4'sd0;
    assign vs_lat_s       = 4'sd0;
`endif

    assign hs0_s = sync_start(HS_NOM, hs_lat_s, HS_MIN, HS_MAX);
    assign vs0_s = sync_start(VS_NOM, vs_lat_s, VS_MIN, VS_MAX);

    // Counters, decoded flags, field and the blank-gated pixel path all advance on ce_pix.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hpos_r    <= {CNT_W{1'b0}};
            vpos_r    <= {CNT_W{1'b0}};
            hblank_r  <= 1'b0;
            vblank_r  <= 1'b0;
            hsync_r   <= ~HS_ON;
            vsync_r   <= ~VS_ON;
            field_r   <= 1'b0;
            rgb_out_r <= {RGB_W{1'b0}};
            de_out_r  <= 1'b0;
        end else if (ce_pix) begin
            hpos_r    <= h_nxt_s;
            vpos_r    <= v_nxt_s;
            hblank_r  <= (h_nxt_s >= H_ACT);
            vblank_r  <= (v_nxt_s >= V_ACT);
            hsync_r   <= in_window(h_nxt_s, hs0_s, HS_LEN) ? HS_ON : ~HS_ON;
            vsync_r   <= in_window(v_nxt_s, vs0_s, VS_LEN) ? VS_ON : ~VS_ON;
            field_r   <= frame_wrap_s ? ~field_r : field_r;
            rgb_out_r <= (hblank_r | vblank_r) ? {RGB_W{1'b0}} : rgb_in;
            de_out_r  <= ~(hblank_r | vblank_r);
        end
    end

    // Strobes mark the clk_sys cycle that carries the wrapping ce_pix, so they cannot be delayed.
    assign line_start  = ce_pix & reset_n & h_wrap_s;
    assign frame_start = ce_pix & reset_n & frame_wrap_s;

    assign hpos    = hpos_r;
    assign vpos    = vpos_r;
    assign hblank  = hblank_r;
    assign vblank  = vblank_r;
    assign hsync   = hsync_r;
    assign vsync   = vsync_r;
    assign field   = field_r;
    assign rgb_out = rgb_out_r;
    assign de_out  = de_out_r;

endmodule
